// File: rtl/voice_allocator_pkg.sv
// rtl/voice_allocator_pkg.sv - slot-state encodings and index sizing shared by the voice allocator
package voice_allocator_pkg;

  // Lifecycle of one voice slot as seen by the allocator
  typedef enum logic [1:0] {
    SLOT_FREE    = 2'd0,
    SLOT_HELD    = 2'd1,
    SLOT_RELEASE = 2'd2,
    SLOT_GAP     = 2'd3
  } slot_state_t;

  localparam int VOICES_MAX = 8;
  localparam int IDX_BITS   = $clog2(VOICES_MAX);

endpackage

// File: rtl/voice_pick.sv
// rtl/voice_pick.sv - combinational candidate selector, one winner per allocation priority class
module voice_pick
  import voice_allocator_pkg::*;
#(
  parameter int VOICES    = 4,
  parameter int NOTE_BITS = 7,
  parameter int AGE_BITS  = 4
) (
  input  logic [VOICES-1:0]           held_pre,
  input  logic [VOICES-1:0]           free_vec,
  input  logic [VOICES-1:0]           rel_vec,
  input  logic [VOICES-1:0]           held_vec,
  input  logic [VOICES*NOTE_BITS-1:0] notes,
  input  logic [VOICES*AGE_BITS-1:0]  ages,
  input  logic [NOTE_BITS-1:0]        on_note,
  output logic                        same_valid,
  output logic [IDX_BITS-1:0]         same_idx,
  output logic                        free_valid,
  output logic [IDX_BITS-1:0]         free_idx,
  output logic                        rel_valid,
  output logic [IDX_BITS-1:0]         rel_idx,
  output logic                        steal_valid,
  output logic [IDX_BITS-1:0]         steal_idx
);

  logic [AGE_BITS-1:0] rel_age;
  logic [AGE_BITS-1:0] steal_age;

  // Lowest-index same-note HELD slot and lowest-index FREE slot
  always_comb begin
    same_valid = 1'b0;
    same_idx   = '0;
    free_valid = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < VOICES; i++) begin
      if (!same_valid && held_pre[i] && notes[i*NOTE_BITS +: NOTE_BITS] == on_note) begin
        same_valid = 1'b1;
        same_idx   = IDX_BITS'(i);
      end
      if (!free_valid && free_vec[i]) begin
        free_valid = 1'b1;
        free_idx   = IDX_BITS'(i);
      end
    end
  end

  // Oldest RELEASE slot and oldest HELD slot; strict compare keeps the lowest index on ties
  always_comb begin
    rel_valid   = 1'b0;
    rel_idx     = '0;
    rel_age     = '0;
    steal_valid = 1'b0;
    steal_idx   = '0;
    steal_age   = '0;
    for (int i = 0; i < VOICES; i++) begin
      if (rel_vec[i] && (!rel_valid || ages[i*AGE_BITS +: AGE_BITS] > rel_age)) begin
        rel_valid = 1'b1;
        rel_idx   = IDX_BITS'(i);
        rel_age   = ages[i*AGE_BITS +: AGE_BITS];
      end
      if (held_vec[i] && (!steal_valid || ages[i*AGE_BITS +: AGE_BITS] > steal_age)) begin
        steal_valid = 1'b1;
        steal_idx   = IDX_BITS'(i);
        steal_age   = ages[i*AGE_BITS +: AGE_BITS];
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - polyphonic note-to-voice allocator (build option: VOICE_STEAL_EN enables voice stealing)
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int VOICES    = 4,
  parameter int NOTE_BITS = 7,
  parameter int AGE_BITS  = 4
) (
  input  logic                        sample_clock,
  input  logic                        rst_n,
  input  logic                        on_valid,
  input  logic [NOTE_BITS-1:0]        on_note,
  output logic                        on_ready,
  input  logic                        off_valid,
  input  logic [NOTE_BITS-1:0]        off_note,
  input  logic [VOICES-1:0]           env_idle,
  output logic [VOICES-1:0]           gate,
  output logic [VOICES*NOTE_BITS-1:0] voice_note,
  output logic                        dropped
);

  slot_state_t         state_q   [VOICES];
  slot_state_t         state_d   [VOICES];
  slot_state_t         state_off [VOICES];
  logic [AGE_BITS-1:0]  age_q    [VOICES];
  logic [AGE_BITS-1:0]  age_d    [VOICES];
  logic [NOTE_BITS-1:0] note_q   [VOICES];
  logic [NOTE_BITS-1:0] note_d   [VOICES];
  logic                 dropped_q;
  logic                 dropped_d;

  logic [VOICES-1:0]           held_pre;
  logic [VOICES-1:0]           free_vec;
  logic [VOICES-1:0]           rel_vec;
  logic [VOICES-1:0]           held_vec;
  logic [VOICES-1:0]           gap_vec;
  logic [VOICES*NOTE_BITS-1:0] notes_flat;
  logic [VOICES*AGE_BITS-1:0]  ages_flat;

  logic                same_valid, free_valid, rel_valid, steal_valid;
  logic [IDX_BITS-1:0] same_idx, free_idx, rel_idx, steal_idx;

  logic                accept;
  logic                alloc_valid;
  logic                alloc_gap;
  logic [IDX_BITS-1:0] alloc_idx;

  // Apply the note-off first, then expose per-class slot vectors and the visible outputs
  always_comb begin
    held_pre   = '0;
    free_vec   = '0;
    rel_vec    = '0;
    held_vec   = '0;
    gap_vec    = '0;
    gate       = '0;
    notes_flat = '0;
    ages_flat  = '0;
    for (int i = 0; i < VOICES; i++) begin
      state_off[i] = state_q[i];
      if (off_valid && (state_q[i] == SLOT_HELD || state_q[i] == SLOT_GAP) && note_q[i] == off_note) begin
        state_off[i] = SLOT_RELEASE;
      end
      held_pre[i] = (state_q[i] == SLOT_HELD);
      gap_vec[i]  = (state_q[i] == SLOT_GAP);
      gate[i]     = (state_q[i] == SLOT_HELD);
      free_vec[i] = (state_off[i] == SLOT_FREE);
      rel_vec[i]  = (state_off[i] == SLOT_RELEASE);
      held_vec[i] = (state_off[i] == SLOT_HELD);
      notes_flat[i*NOTE_BITS +: NOTE_BITS] = note_q[i];
      ages_flat[i*AGE_BITS +: AGE_BITS]    = age_q[i];
    end
  end

  assign voice_note = notes_flat;
  assign on_ready   = ~|gap_vec;
  assign dropped    = dropped_q;
  assign accept     = on_valid && on_ready;

  // Same-note matching looks at pre-off state so an on+off of one note retriggers that slot
  voice_pick #(
    .VOICES    (VOICES),
    .NOTE_BITS (NOTE_BITS),
    .AGE_BITS  (AGE_BITS)
  ) u_pick (
    .held_pre    (held_pre),
    .free_vec    (free_vec),
    .rel_vec     (rel_vec),
    .held_vec    (held_vec),
    .notes       (notes_flat),
    .ages        (ages_flat),
    .on_note     (on_note),
    .same_valid  (same_valid),
    .same_idx    (same_idx),
    .free_valid  (free_valid),
    .free_idx    (free_idx),
    .rel_valid   (rel_valid),
    .rel_idx     (rel_idx),
    .steal_valid (steal_valid),
    .steal_idx   (steal_idx)
  );

`ifndef VOICE_STEAL_EN
  logic unused_steal;
  assign unused_steal = ^{steal_valid, steal_idx};
`endif

  // Priority resolution: retrigger, then free, then oldest released, then (optionally) oldest held
  always_comb begin
    alloc_valid = 1'b0;
    alloc_gap   = 1'b0;
    alloc_idx   = '0;
    if (same_valid) begin
      alloc_valid = 1'b1;
      alloc_gap   = 1'b1;
      alloc_idx   = same_idx;
    end else if (free_valid) begin
      alloc_valid = 1'b1;
      alloc_idx   = free_idx;
    end else if (rel_valid) begin
      alloc_valid = 1'b1;
      alloc_idx   = rel_idx;
    end
`ifdef VOICE_STEAL_EN
    else if (steal_valid) begin
      alloc_valid = 1'b1;
      alloc_gap   = 1'b1;
      alloc_idx   = steal_idx;
    end
`endif
  end

  // Per-slot next state, note capture and age bookkeeping
  always_comb begin
    dropped_d = accept && !alloc_valid;
    for (int i = 0; i < VOICES; i++) begin
      note_d[i] = note_q[i];
      age_d[i]  = age_q[i];
      case (state_off[i])
        SLOT_GAP:     state_d[i] = SLOT_HELD;
        SLOT_RELEASE: state_d[i] = env_idle[i] ? SLOT_FREE : SLOT_RELEASE;
        default:      state_d[i] = state_off[i];
      endcase
      if (accept && alloc_valid) begin
        if (alloc_idx == IDX_BITS'(i)) begin
          state_d[i] = alloc_gap ? SLOT_GAP : SLOT_HELD;
          note_d[i]  = on_note;
          age_d[i]   = '0;
        end else if (state_off[i] != SLOT_FREE && age_q[i] != '1) begin
          age_d[i] = age_q[i] + 1'b1;
        end
      end
    end
  end

  // State, note and age registers
  always_ff @(posedge sample_clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < VOICES; i++) begin
        state_q[i] <= SLOT_FREE;
        age_q[i]   <= '0;
        note_q[i]  <= '0;
      end
      dropped_q <= 1'b0;
    end else begin
      for (int i = 0; i < VOICES; i++) begin
        state_q[i] <= state_d[i];
        age_q[i]   <= age_d[i];
        note_q[i]  <= note_d[i];
      end
      dropped_q <= dropped_d;
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - scoreboard bench for voice_allocator (VOICES=4, either VOICE_STEAL_EN build)
module tb_voice_allocator;

  localparam int VOICES = 4;
  localparam int NB     = 7;

  logic              sample_clock = 1'b0;
  logic              rst_n        = 1'b0;
  logic              on_valid     = 1'b0;
  logic [NB-1:0]     on_note      = '0;
  logic              off_valid    = 1'b0;
  logic [NB-1:0]     off_note     = '0;
  logic [VOICES-1:0] env_idle     = '0;
  logic              on_ready;
  logic              dropped;
  logic [VOICES-1:0] gate;
  logic [VOICES*NB-1:0] voice_note;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n0;

  typedef struct {
    int          cyc;
    logic [3:0]  gate;
    logic [27:0] notes;
    logic        ready;
    logic        drop;
    string       tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  voice_allocator #(.VOICES(VOICES), .NOTE_BITS(NB), .AGE_BITS(4)) dut (
    .sample_clock (sample_clock),
    .rst_n        (rst_n),
    .on_valid     (on_valid),
    .on_note      (on_note),
    .on_ready     (on_ready),
    .off_valid    (off_valid),
    .off_note     (off_note),
    .env_idle     (env_idle),
    .gate         (gate),
    .voice_note   (voice_note),
    .dropped      (dropped)
  );

  always #5 sample_clock = ~sample_clock;

  always @(posedge sample_clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [27:0] nv(input int a3, input int a2, input int a1, input int a0);
    return {7'(a3), 7'(a2), 7'(a1), 7'(a0)};
  endfunction

  // Drive one cycle of stimulus and queue what must be visible after the next edge
  task automatic step(input logic onv, input int onn, input logic offv, input int offn,
                      input logic [3:0] idle, input logic [3:0] eg, input logic [27:0] en,
                      input logic er, input logic ed, input string tag);
    exp_t e;
    @(posedge sample_clock);
    #1;
    on_valid  = onv;
    on_note   = NB'(onn);
    off_valid = offv;
    off_note  = NB'(offn);
    env_idle  = idle;
    e.cyc   = cyc + 1;
    e.gate  = eg;
    e.notes = en;
    e.ready = er;
    e.drop  = ed;
    e.tag   = tag;
    sb.push_back(e);
  endtask

  always @(negedge sample_clock) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      check({mon_e.tag, " gate"},  32'(gate),       32'(mon_e.gate));
      check({mon_e.tag, " notes"}, 32'(voice_note), 32'(mon_e.notes));
      check({mon_e.tag, " ready"}, 32'(on_ready),   32'(mon_e.ready));
      check({mon_e.tag, " drop"},  32'(dropped),    32'(mon_e.drop));
    end
  end

  task automatic drain(input string tag);
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge sample_clock);
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef VOICE_STEAL_EN
    n0 = 67;
`else
    n0 = 60;
`endif
    rst_n = 1'b0;
    repeat (3) @(posedge sample_clock);
    #1;
    check("reset gate",  32'(gate),       32'd0);
    check("reset notes", 32'(voice_note), 32'd0);
    check("reset ready", 32'(on_ready),   32'd1);
    check("reset drop",  32'(dropped),    32'd0);
    rst_n = 1'b1;

    step(1, 60, 0, 0, 4'b0000, 4'b0001, nv(0, 0, 0, 60),    1, 0, "on60");
    step(1, 62, 0, 0, 4'b0000, 4'b0011, nv(0, 0, 62, 60),   1, 0, "on62");
    step(1, 64, 0, 0, 4'b0000, 4'b0111, nv(0, 64, 62, 60),  1, 0, "on64");
    step(1, 65, 0, 0, 4'b0000, 4'b1111, nv(65, 64, 62, 60), 1, 0, "on65");
`ifdef VOICE_STEAL_EN
    step(1, 67, 0, 0, 4'b0000, 4'b1110, nv(65, 64, 62, 67), 0, 0, "steal67");
`else
    step(1, 67, 0, 0, 4'b0000, 4'b1111, nv(65, 64, 62, 60), 1, 1, "drop67");
`endif
    step(0, 0, 0, 0, 4'b0000, 4'b1111, nv(65, 64, 62, n0), 1, 0, "after67");
    step(0, 0, 1, 65, 4'b0000, 4'b0111, nv(65, 64, 62, n0), 1, 0, "off65");
    step(0, 0, 0, 0, 4'b1000, 4'b0111, nv(65, 64, 62, n0), 1, 0, "idle3");
    step(0, 0, 1, 62, 4'b0000, 4'b0101, nv(65, 64, 62, n0), 1, 0, "off62");
    step(1, 70, 0, 0, 4'b0000, 4'b1101, nv(70, 64, 62, n0), 1, 0, "on70_free");
    step(1, 72, 0, 0, 4'b0000, 4'b1111, nv(70, 64, 72, n0), 1, 0, "on72_rel");
    step(0, 0, 0, 0, 4'b0010, 4'b1111, nv(70, 64, 72, n0), 1, 0, "idle_on_held");
    step(1, n0, 1, n0, 4'b0000, 4'b1110, nv(70, 64, 72, n0), 0, 0, "onoff_same");
    step(0, 0, 0, 0, 4'b0000, 4'b1111, nv(70, 64, 72, n0), 1, 0, "retrig_end");
    step(0, 0, 1, 99, 4'b0000, 4'b1111, nv(70, 64, 72, n0), 1, 0, "off_unmatched");
    step(1, 72, 0, 0, 4'b0000, 4'b1101, nv(70, 64, 72, n0), 0, 0, "retrig72");
    step(1, 80, 1, 64, 4'b0000, 4'b1011, nv(70, 64, 72, n0), 1, 0, "busy_on_off64");
    step(1, 70, 0, 0, 4'b0000, 4'b0011, nv(70, 64, 72, n0), 0, 0, "retrig70");
    step(0, 0, 1, 70, 4'b0000, 4'b0011, nv(70, 64, 72, n0), 1, 0, "off_gap70");
    step(0, 0, 0, 0, 4'b1000, 4'b0011, nv(70, 64, 72, n0), 1, 0, "idle3b");
    step(1, 90, 0, 0, 4'b0000, 4'b1011, nv(90, 64, 72, n0), 1, 0, "on90_free");
    step(0, 0, 0, 0, 4'b0000, 4'b1011, nv(90, 64, 72, n0), 1, 0, "quiet");
    drain("sb drain");

    @(posedge sample_clock);
    #1;
    rst_n = 1'b0;
    @(posedge sample_clock);
    #1;
    check("midreset gate",  32'(gate),       32'd0);
    check("midreset notes", 32'(voice_note), 32'd0);
    check("midreset ready", 32'(on_ready),   32'd1);
    check("midreset drop",  32'(dropped),    32'd0);
    rst_n = 1'b1;

    step(1, 61, 0, 0, 4'b0000, 4'b0001, nv(0, 0, 0, 61), 1, 0, "post_reset_on61");
    drain("sb drain2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
